// File: rtl/serial_link_pkg.sv
// Shared definitions for the XOR-parity serial link.
// Used by both the receiver and the matching transmitter.
package serial_link_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } link_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_parity_rx_parity_acc.sv
// One-bit running XOR accumulator for the serial link.
// Clear loads the parity seed so odd/even is a build choice.
module parity_acc #(
    parameter bit ODD = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic par
);

    logic par_nxt;

    assign par_nxt = par ^ din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par <= 1'b0;
        end else if (clr) begin
            par <= ODD;
        end else if (en) begin
            par <= par_nxt;
        end
    end

endmodule

// File: rtl/serial_parity_rx.sv
// Serial receiver: deframes start, W data bits LSB first, parity, stop
// and offers the word through a valid/ack handshake.
module serial_parity_rx
    import serial_link_pkg::*;
#(
    parameter int W   = 8,
    parameter bit ODD = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sin,
    input  logic         ack,
    output logic [W-1:0] data,
    output logic         valid,
    output logic         par_err,
    output logic         frame_err,
    output logic         overrun,
    output logic         busy
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    link_state_t   state;
    link_state_t   state_nxt;
    logic [CW-1:0] cnt;
    logic [W-1:0]  sr;
    logic [W-1:0]  sr_nxt;
    logic          par_clr;
    logic          par_en;
    logic          shift_en;
    logic          load;
    logic          par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        par_clr   = 1'b0;
        par_en    = 1'b0;
        shift_en  = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (sin == START_BIT) begin
                    par_clr   = 1'b1;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                shift_en = 1'b1;
                par_en   = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = PARITY;
                end
            end
            PARITY: begin
                par_en    = 1'b1;
                state_nxt = STOP;
            end
            STOP: begin
                load      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Bits arrive LSB first, so each new bit enters at the top.
    generate
        if (W == 1) begin : g_sr_one
            assign sr_nxt = sin;
        end else begin : g_sr_wide
            assign sr_nxt = {sin, sr[W-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sr  <= '0;
        end else if (par_clr) begin
            cnt <= '0;
        end else if (shift_en) begin
            cnt <= cnt + 1'b1;
            sr  <= sr_nxt;
        end
    end

    parity_acc #(
        .ODD (ODD)
    ) u_parity_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (par_clr),
        .en    (par_en),
        .din   (sin),
        .par   (par)
    );

    // A load beats a same-cycle ack: the new word is never dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data      <= '0;
            valid     <= 1'b0;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else if (load) begin
            data      <= sr;
            valid     <= 1'b1;
            par_err   <= par;
            frame_err <= (sin != STOP_BIT);
            if (valid && !ack) begin
                overrun <= 1'b1;
            end
        end else if (valid && ack) begin
            valid <= 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed bench for serial_parity_rx: even, odd and W=1 builds.
module tb_serial_parity_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sin0 = 1'b1, sin1 = 1'b1, sin2 = 1'b1;
    logic       ack0 = 1'b0, ack1 = 1'b0, ack2 = 1'b0;
    logic [7:0] data0, data1;
    logic [0:0] data2;
    logic       valid0, valid1, valid2;
    logic       pe0, pe1, pe2;
    logic       fe0, fe1, fe2;
    logic       ov0, ov1, ov2;
    logic       busy0, busy1, busy2;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    serial_parity_rx #(.W(8), .ODD(1'b0)) u_even (
        .clk(clk), .rst_n(rst_n), .sin(sin0), .ack(ack0),
        .data(data0), .valid(valid0), .par_err(pe0),
        .frame_err(fe0), .overrun(ov0), .busy(busy0)
    );

    serial_parity_rx #(.W(8), .ODD(1'b1)) u_odd (
        .clk(clk), .rst_n(rst_n), .sin(sin1), .ack(ack1),
        .data(data1), .valid(valid1), .par_err(pe1),
        .frame_err(fe1), .overrun(ov1), .busy(busy1)
    );

    serial_parity_rx #(.W(1), .ODD(1'b0)) u_w1 (
        .clk(clk), .rst_n(rst_n), .sin(sin2), .ack(ack2),
        .data(data2), .valid(valid2), .par_err(pe2),
        .frame_err(fe2), .overrun(ov2), .busy(busy2)
    );

    task automatic drive(input int sel, input logic b);
        @(negedge clk);
        case (sel)
            0:       sin0 = b;
            1:       sin1 = b;
            default: sin2 = b;
        endcase
    endtask

    // Leaves the stop bit on the line; the caller owns the stop edge.
    task automatic send_frame(input int sel, input logic [31:0] word,
                              input int nbits, input logic par,
                              input logic stop);
        drive(sel, 1'b0);
        for (int i = 0; i < nbits; i++) drive(sel, word[i]);
        drive(sel, par);
        drive(sel, stop);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sin0 = 1'b1; sin1 = 1'b1; sin2 = 1'b1;
        ack0 = 1'b0; ack1 = 1'b0; ack2 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        drive(0, 1'b0);
        drive(0, 1'b1);
        drive(0, 1'b0);
        @(posedge clk); #1;
        n_cmp++;
        if (busy0 !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_pre_busy: got %b want 1", busy0);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy0 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async_busy: got %b want 0", busy0);
        end
        @(negedge clk);
        sin0 = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({valid0, busy0, pe0, fe0, ov0, data0} !== 13'h0) begin
                n_bad++;
                $display("FAIL reset_idle[%0d]: got v%b b%b p%b f%b o%b d%h want all 0",
                         i, valid0, busy0, pe0, fe0, ov0, data0);
            end
        end
    endtask

    task automatic test_good_frame();
        send_frame(0, 32'hA5, 8, 1'b0, 1'b1);
        n_cmp++;
        if (valid0 !== 1'b0) begin
            n_bad++;
            $display("FAIL good_pre_stop_valid: got %b want 0", valid0);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({valid0, pe0, fe0, data0} !== {3'b100, 8'hA5}) begin
            n_bad++;
            $display("FAIL good_frame: got v%b p%b f%b d%h want v1 p0 f0 da5",
                     valid0, pe0, fe0, data0);
        end
        @(negedge clk);
        ack0 = 1'b1;
        @(posedge clk); #1;
        ack0 = 1'b0;
        n_cmp++;
        if ({valid0, data0} !== {1'b0, 8'hA5}) begin
            n_bad++;
            $display("FAIL good_ack: got v%b d%h want v0 da5", valid0, data0);
        end
    endtask

    task automatic test_parity_err();
        send_frame(0, 32'h01, 8, 1'b0, 1'b1);
        @(posedge clk); #1;
        n_cmp++;
        if ({valid0, pe0, fe0, data0} !== {3'b110, 8'h01}) begin
            n_bad++;
            $display("FAIL parity_even: got v%b p%b f%b d%h want v1 p1 f0 d01",
                     valid0, pe0, fe0, data0);
        end
        @(negedge clk);
        ack0 = 1'b1;
        @(posedge clk); #1;
        ack0 = 1'b0;
        send_frame(1, 32'h01, 8, 1'b0, 1'b1);
        @(posedge clk); #1;
        n_cmp++;
        if ({valid1, pe1, fe1, data1} !== {3'b100, 8'h01}) begin
            n_bad++;
            $display("FAIL parity_odd: got v%b p%b f%b d%h want v1 p0 f0 d01",
                     valid1, pe1, fe1, data1);
        end
    endtask

    task automatic test_framing();
        send_frame(0, 32'h3C, 8, 1'b0, 1'b0);
        @(posedge clk); #1;
        n_cmp++;
        if ({valid0, pe0, fe0, data0} !== {3'b101, 8'h3C}) begin
            n_bad++;
            $display("FAIL framing: got v%b p%b f%b d%h want v1 p0 f1 d3c",
                     valid0, pe0, fe0, data0);
        end
        @(negedge clk);
        sin0 = 1'b1;
        ack0 = 1'b1;
        @(posedge clk); #1;
        ack0 = 1'b0;
        n_cmp++;
        if (valid0 !== 1'b0) begin
            n_bad++;
            $display("FAIL framing_ack: got %b want 0", valid0);
        end
        send_frame(0, 32'h55, 8, 1'b0, 1'b1);
        @(posedge clk); #1;
        n_cmp++;
        if ({valid0, pe0, fe0, ov0, data0} !== {4'b1000, 8'h55}) begin
            n_bad++;
            $display("FAIL framing_next: got v%b p%b f%b o%b d%h want v1 p0 f0 o0 d55",
                     valid0, pe0, fe0, ov0, data0);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        send_frame(0, 32'h11, 8, 1'b0, 1'b1);
        send_frame(0, 32'h22, 8, 1'b0, 1'b1);
        @(posedge clk); #1;
        n_cmp++;
        if ({valid0, ov0, data0} !== {2'b11, 8'h22}) begin
            n_bad++;
            $display("FAIL overrun: got v%b o%b d%h want v1 o1 d22",
                     valid0, ov0, data0);
        end
        @(negedge clk);
        ack0 = 1'b1;
        @(posedge clk); #1;
        ack0 = 1'b0;
        n_cmp++;
        if ({valid0, ov0} !== 2'b01) begin
            n_bad++;
            $display("FAIL overrun_sticky: got v%b o%b want v0 o1", valid0, ov0);
        end
    endtask

    task automatic test_simul_ack();
        do_reset();
        n_cmp++;
        if (ov0 !== 1'b0) begin
            n_bad++;
            $display("FAIL simul_reset_ov: got %b want 0", ov0);
        end
        send_frame(0, 32'h11, 8, 1'b0, 1'b1);
        send_frame(0, 32'h22, 8, 1'b0, 1'b1);
        ack0 = 1'b1;
        @(posedge clk); #1;
        ack0 = 1'b0;
        n_cmp++;
        if ({valid0, ov0, data0} !== {2'b10, 8'h22}) begin
            n_bad++;
            $display("FAIL simul_ack: got v%b o%b d%h want v1 o0 d22",
                     valid0, ov0, data0);
        end
    endtask

    task automatic test_w1();
        drive(2, 1'b0);
        @(posedge clk); #1;
        n_cmp++;
        if ({busy2, valid2} !== 2'b10) begin
            n_bad++;
            $display("FAIL w1_start: got b%b v%b want b1 v0", busy2, valid2);
        end
        drive(2, 1'b1);
        drive(2, 1'b1);
        @(posedge clk); #1;
        n_cmp++;
        if (valid2 !== 1'b0) begin
            n_bad++;
            $display("FAIL w1_early: got %b want 0", valid2);
        end
        drive(2, 1'b1);
        @(posedge clk); #1;
        n_cmp++;
        if ({valid2, pe2, fe2, data2, busy2} !== 5'b10010) begin
            n_bad++;
            $display("FAIL w1_frame: got v%b p%b f%b d%b b%b want v1 p0 f0 d1 b0",
                     valid2, pe2, fe2, data2, busy2);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_err();
        test_framing();
        test_overrun();
        test_simul_ack();
        test_w1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_parity_rx.md
Name: serial_parity_rx

Overview:
- Receiving end of the team's XOR-parity serial link. Samples one bit per clock on a single serial line and deframes start, W data bits (LSB first), parity and stop.
- Recomputes parity with an XOR reduction and flags parity and framing errors.
- Presents the received word through a valid/ack handshake to downstream logic.
- Sits between the serial pin and any consumer of parallel words.

Parameters:
- W, 8, data bits per frame (legal range 1..32).
- ODD, 0, 0 = even parity (XOR of data and parity bits must be 0); 1 = odd parity (XOR must be 1).

Ports:
- clk  input  1  rising-edge clock; one serial bit per cycle.
- rst_n  input  1  asynchronous active-low reset.
- sin  input  1  serial line, idles high; assumed synchronous to clk.
- ack  input  1  consumer accepts the current word; meaningful only while valid=1.
- data  output  W  last received data word.
- valid  output  1  data and error flags hold an unconsumed frame.
- par_err  output  1  parity mismatch for the frame in data.
- frame_err  output  1  stop bit sampled as 0 for the frame in data.
- overrun  output  1  sticky; a frame completed while valid=1 and no ack arrived that cycle.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0): FSM=IDLE; data=0, valid=0, par_err=0, frame_err=0, overrun=0, busy=0; shift register, bit counter and running parity all cleared. Reset mid-frame abandons the frame and produces no output.
- Reset release takes effect on the first clk edge after rst_n=1.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: sin=0 sampled -> DATA; counter=0; running parity=ODD. sin=1 -> stay.
  - DATA: shift sin into the MSB of the shift register (LSB-first arrival); XOR it into the running parity; counter+1. When counter=W-1 is sampled -> PARITY.
  - PARITY: XOR sin into the running parity -> STOP. After this, a running parity of 1 means par_err.
  - STOP: sample sin. Load data = shift register, par_err = running parity, frame_err = ~sin. Set valid=1 -> IDLE. The load is registered: the outputs change on the edge that samples the stop bit.
- Frame length is W+3 cycles from start-bit sample to stop-bit sample. valid rises on the stop-bit edge.
- Back-to-back frames: a start bit may be sampled on the cycle immediately after STOP. There is no idle gap requirement.
- A frame with frame_err=1 is still delivered with valid=1. The FSM returns to IDLE and does not attempt to resynchronise.
- Handshake:
  - valid stays high until a clk edge with ack=1; that edge clears valid.
  - ack while valid=0 is ignored.
  - data and the error flags hold their values while valid=0; they change only on a load.
- Simultaneous events at the STOP load edge:
  - load and ack on the same edge: the load wins. valid stays 1 with the new word; no overrun.
  - load with valid=1 and ack=0: the new word overwrites, valid stays 1, overrun set to 1.
  - overrun clears only on reset.
- busy=1 in DATA, PARITY and STOP.

Decomposition:
- Shared package serial_link_pkg holds:
  - FSM state typedef (IDLE/DATA/PARITY/STOP, 2 bits);
  - constants START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1.
- The team's matching transmitter imports the same package.
- One natural sub-module: parity_acc. It is a 1-bit XOR accumulator with clear-to-ODD, enable and serial input, built on the existing two-input XOR cell.
- FSM, counter and shift register stay in the top module.

Test Plan (W=8, ODD=0 unless stated):
- Reset: hold rst_n=0 mid-frame, then release with sin=1 for 20 cycles -> valid, busy and all flags stay 0; data=0x00.
- Good frame: start, 0xA5 LSB-first, parity 0, stop 1 -> on the stop edge data=0xA5, valid=1, par_err=0, frame_err=0. Then ack=1 for one cycle -> valid=0 and data holds 0xA5.
- Parity error: 0x01 with parity 0 -> par_err=1, data=0x01. Repeat with ODD=1 and parity 0 -> par_err=0.
- Framing error: 0x3C with correct parity and stop bit 0 -> frame_err=1, valid=1. A following start bit still decodes the next frame (0x55) correctly.
- Overrun and simultaneous ack:
  - Two back-to-back frames 0x11, 0x22 with no ack -> data=0x22, overrun=1, valid=1.
  - After reset, repeat with ack asserted on the second frame's stop edge -> data=0x22, valid=1, overrun=0.
- W=1 build: start, data 1, parity 1, stop -> data=1, par_err=0; total latency 4 cycles from start-bit sample to stop-bit sample.
